// File: rtl/system_0_button_pio_in.sv
// ---------------------------------------------------------------------------
// system_0_button_pio_in
//   Avalon-MM slave input PIO for pushbuttons and switches. The asynchronous
//   pins pass through a 2-flop synchronizer and a per-bit debouncer. The
//   debounced value, a per-bit interrupt mask and a per-bit edge-capture
//   register are visible to the processor. A level IRQ is raised while any
//   unmasked edge-capture bit is set.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   address    in   [1:0] word address (0 data, 1 reserved, 2 irqmask,
//                   3 edgecapture)
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   [31:0] write data
//   in_port    in   [WIDTH-1:0] asynchronous external pins
//   readdata   out  [31:0] zero-extended read data, combinational
//   irq        out  level interrupt, active-high
// ---------------------------------------------------------------------------
module system_0_button_pio_in #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;

  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             unused_wdata;

  // Only writedata[WIDTH-1:0] is meaningful; the rest is deliberately ignored.
  assign unused_wdata = ^writedata;

  // Synchronizer and per-bit debounce counters.
  always_comb begin
    sync1_d  = in_port;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    upd      = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          upd[i]      = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Edge qualification uses the value being loaded into stable this cycle,
  // so edgecapture sets on the same clock edge that stable changes.
  always_comb begin
    set_bits = '0;
    case (EDGE_TYPE)
      0:       set_bits = upd & ~sync2_q;
      1:       set_bits = upd &  sync2_q;
      default: set_bits = upd;
    endcase
  end

  // Register writes. Set takes priority over a same-cycle write-1-to-clear.
  always_comb begin
    wr_en     = chipselect & ~write_n;
    irqmask_d = irqmask_q;
    clr_bits  = '0;
    if (wr_en && (address == 2'd2)) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && (address == 2'd3)) clr_bits  = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= RESET_VALUE;
      sync2_q   <= RESET_VALUE;
      stable_q  <= RESET_VALUE;
      edgecap_q <= '0;
      irqmask_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      edgecap_q <= edgecap_d;
      irqmask_q <= irqmask_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Zero-wait-state read mux; unused upper bits and reserved address read 0.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable_q;
      2'd2:    readdata[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata[WIDTH-1:0] = edgecap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule
